wb_conmax_slave_arb: RTL and testbench
======================================

// Module: wb_conmax_slave_arb
// PURPOSE
//  - Per-slave arbiter for the Wishbone connection matrix. Selects one of 8 masters requesting a slave.
//  - Selection uses each master's one-hot priority vector from its priority decoder, with round-robin inside a level.
//  - Holds the grant for the full bus cycle.
//  - Drives the slave-side master mux select and the grant-valid qualifier.
// PARAMETERS
//  - TO_W     8    width of hold-timeout counter (used only with WB_CONMAX_ARB_TIMEOUT_EN)
//  - MAX_HOLD 255  cycles a master may hold the grant before forced release (< 2**TO_W)
// PORTS
//  - clk_i      in   1   system clock, all state on rising edge
//  - rst_ni     in   1   asynchronous active-low reset
//  - req_i      in   8   req_i[m] = master m cyc asserted and addressing this slave
//  - pri_i      in   32  pri_i[4m+3:4m] = master m one-hot priority vector (4'h0 legal)
//  - gnt_o      out  3   encoded index of granted master
//  - gnt_vld_o  out  1   grant is active, gnt_o valid
//  - gnt_chg_o  out  1   one-cycle pulse: grant owner changed at this edge
//  - to_o       out  1   one-cycle pulse: grant was forcibly released (timeout build only)
// BEHAVIOUR
//  - Reset (async, rst_ni=0):
//    - gnt_o=3'd0, gnt_vld_o=0, gnt_chg_o=0, to_o=0
//    - RR pointer last=3'd7, so master 0 wins the first tie
//  - Level of master m = index of the highest set bit of its vector. 4'h0 and 4'b0001 both give level 0.
//  - Winner (combinational, from current req_i/pri_i):
//    - Candidates are requesters whose level equals the maximum level among all requesters.
//    - Pick the first candidate searching last+1, last+2, ... wrapping mod 8.
//  - States: IDLE (gnt_vld_o=0), BUSY (gnt_vld_o=1).
//  - IDLE: if any req_i bit is set:
//    - gnt_o<=winner, last<=winner, BUSY, gnt_chg_o<=1
//    - Latency: req at edge n -> grant visible after edge n+1.
//  - BUSY, req_i[gnt_o]=1: hold. No preemption, even by a higher-priority requester.
//  - BUSY, req_i[gnt_o]=0 (owner ended cycle):
//    - Re-arbitrate at the same edge. The old owner's req bit is 0, so it is excluded automatically.
//    - If a winner exists: switch with no bubble, gnt_chg_o<=1.
//    - Otherwise: IDLE, gnt_vld_o<=0, gnt_o keeps its last value.
//  - gnt_chg_o and to_o are high only on the cycle after the causing edge.
//  - Simultaneous events:
//    - Owner drop and new request on the same edge: the new request competes in that edge's arbitration.
//    - Changes to pri_i while BUSY do not affect the current grant.
//  - The RR pointer updates only on a grant. Levels do not affect the pointer.
//  - Reset asserted mid-cycle: all outputs return to reset values immediately. No grant survives.
// CONFIGURATION
//  - WB_CONMAX_ARB_TIMEOUT_EN defined:
//    - A TO_W-bit hold counter clears on every grant and increments each BUSY cycle.
//    - When the counter reaches MAX_HOLD with the owner still requesting:
//      - Re-arbitrate with the owner masked out; to_o<=1.
//      - If no other requester exists: the grant stays with the owner, the counter clears, to_o still pulses.
//  - Macro undefined: no counter; to_o tied 0; grants held indefinitely.
// TESTING
//  - Reset: rst_ni=0 while req_i=8'hFF -> gnt_vld_o=0, gnt_o=0. Release -> next edge gnt_o=0, gnt_vld_o=1, gnt_chg_o pulse.
//  - Round-robin: all pri 4'b0001, req_i=8'b0010_1001 held, each owner drops req for 1 cycle then re-raises.
//    -> grants 0,3,5,0 in order.
//  - Priority: m2 pri=4'b0100, m6 pri=4'b0001, both request from IDLE -> gnt_o=2.
//    - m2 drops -> gnt_o=6 on the same edge, no IDLE cycle.
//  - No preemption: m1 (level 0) owns the grant; m4 raises req with pri=4'b1000 -> gnt_o stays 1 until m1 drops, then 4.
//  - Idle and zero priority: single requester m7 with pri=4'h0 -> gnt_o=7. m7 drops -> gnt_vld_o=0, gnt_o stays 7.
//  - Timeout (macro on, MAX_HOLD=4):
//    - m0 holds, m1 requests -> to_o pulse after 4 BUSY cycles, gnt_o=1.
//    - m0 alone -> to_o pulses, gnt_o stays 0.

Source files
------------

// File: rtl/wb_conmax_arb_if.sv
// Request/priority inputs and grant outputs shared by a Wishbone conmax slave
// arbiter and the logic that drives it.
interface wb_conmax_arb_if;
  logic [7:0]  req_i;
  logic [31:0] pri_i;
  logic [2:0]  gnt_o;
  logic        gnt_vld_o;
  logic        gnt_chg_o;
  logic        to_o;

  modport master (
    output req_i,
    output pri_i,
    input  gnt_o,
    input  gnt_vld_o,
    input  gnt_chg_o,
    input  to_o
  );

  modport slave (
    input  req_i,
    input  pri_i,
    output gnt_o,
    output gnt_vld_o,
    output gnt_chg_o,
    output to_o
  );
endinterface

// File: rtl/wb_conmax_slave_arb.sv
// Per-slave 8-master arbiter: priority levels with round-robin inside a level,
// grant held for the whole bus cycle. WB_CONMAX_ARB_TIMEOUT_EN adds forced release.
module wb_conmax_slave_arb #(
  parameter int unsigned TO_W     = 8,
  parameter int unsigned MAX_HOLD = 255
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  wb_conmax_arb_if.slave  bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  if (MAX_HOLD < 1 || MAX_HOLD >= (64'd1 << TO_W)) begin : g_bad_max_hold
    $error("MAX_HOLD must be in 1 .. 2**TO_W-1");
  end

  logic [0:0] state_q, state_d;
  logic [2:0] gnt_q, gnt_d;
  logic [2:0] last_q, last_d;
  logic       chg_q, chg_d;
  logic       to_q, to_d;

  logic [1:0] lvl [8];
  logic [1:0] max_lvl;
  logic [7:0] arb_req;
  logic [7:0] cand;
  logic [2:0] win;
  logic [2:0] idx;
  logic       win_vld;
  logic       owner_req;
  logic       hold_to;
  logic       grant;

  function automatic logic [1:0] level_of(input logic [3:0] v);
    if (v[3])      return 2'd3;
    else if (v[2]) return 2'd2;
    else if (v[1]) return 2'd1;
    else           return 2'd0;
  endfunction

  assign owner_req = bus.req_i[gnt_q];

`ifdef WB_CONMAX_ARB_TIMEOUT_EN
  localparam logic [TO_W-1:0] HOLD_LAST = TO_W'(MAX_HOLD - 1);

  logic [TO_W-1:0] hold_q, hold_d;

  assign hold_to = (state_q == ST_BUSY) && owner_req && (hold_q == HOLD_LAST);

  always_comb begin
    hold_d = hold_q;
    if (grant || hold_to) begin
      hold_d = '0;
    end else if (state_q == ST_BUSY) begin
      hold_d = hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  assign hold_to = 1'b0;
`endif

  // On a forced release the current owner must not win its own re-arbitration.
  assign arb_req = bus.req_i & ~(hold_to ? (8'b1 << gnt_q) : 8'b0);

  always_comb begin
    max_lvl = 2'd0;
    for (int m = 0; m < 8; m++) begin
      lvl[m] = level_of(bus.pri_i[4*m +: 4]);
      if (arb_req[m] && (lvl[m] > max_lvl)) begin
        max_lvl = lvl[m];
      end
    end
    for (int m = 0; m < 8; m++) begin
      cand[m] = arb_req[m] && (lvl[m] == max_lvl);
    end
  end

  always_comb begin
    win     = 3'd0;
    win_vld = 1'b0;
    idx     = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      idx = last_q + 3'(k);
      if (!win_vld && cand[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    chg_d   = 1'b0;
    to_d    = 1'b0;
    grant   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        grant = win_vld;
      end
      ST_BUSY: begin
        if (!owner_req) begin
          grant = win_vld;
          if (!win_vld) begin
            state_d = ST_IDLE;
          end
        end else if (hold_to) begin
          to_d  = 1'b1;
          grant = win_vld;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (grant) begin
      gnt_d   = win;
      last_d  = win;
      state_d = ST_BUSY;
      chg_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      gnt_q   <= 3'd0;
      last_q  <= 3'd7;
      chg_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      chg_q   <= chg_d;
      to_q    <= to_d;
    end
  end

  assign bus.gnt_o     = gnt_q;
  assign bus.gnt_vld_o = (state_q == ST_BUSY);
  assign bus.gnt_chg_o = chg_q;
  assign bus.to_o      = to_q;

endmodule

// File: tb/tb_wb_conmax_slave_arb.sv
// Bench for wb_conmax_slave_arb: vector table plus hand-written reset and hold sequences.
module tb_wb_conmax_slave_arb;

  typedef struct {
    logic [7:0]  req;
    logic [31:0] pri;
    logic [2:0]  gnt;
    logic        vld;
    logic        chg;
    logic        to;
  } vec_t;

  typedef struct {
    logic [2:0] gnt;
    logic       vld;
    logic       chg;
    logic       to;
    string      name;
  } exp_t;

  localparam logic [31:0] P1 = 32'h1111_1111;
  localparam logic [31:0] PP = 32'h0100_0400;
  localparam logic [31:0] PN = 32'h0008_0010;
  localparam logic [31:0] PL = 32'h0020_2000;
  localparam logic [31:0] PH = 32'h0020_2008;
  localparam int NVEC = 29;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];
  vec_t vecs[NVEC];

  always #5 clk = ~clk;

  wb_conmax_arb_if bus ();

  wb_conmax_slave_arb #(
    .TO_W    (8),
    .MAX_HOLD(4)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  task automatic expect_out(input logic [2:0] gnt, input logic vld, input logic chg,
                            input logic to, input string name);
    exp_t e;
    e.gnt = gnt; e.vld = vld; e.chg = chg; e.to = to; e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: no expected entry queued");
      return;
    end
    e = sb_q.pop_front();
    if (bus.gnt_o !== e.gnt || bus.gnt_vld_o !== e.vld ||
        bus.gnt_chg_o !== e.chg || bus.to_o !== e.to) begin
      n_fail++;
      $display("FAIL %s: got gnt=%0d vld=%b chg=%b to=%b, expected gnt=%0d vld=%b chg=%b to=%b",
               e.name, bus.gnt_o, bus.gnt_vld_o, bus.gnt_chg_o, bus.to_o,
               e.gnt, e.vld, e.chg, e.to);
    end
  endtask

  // Drive inputs just after an edge, then check what the next edge produced.
  task automatic step(input logic [7:0] req, input logic [31:0] pri, input logic [2:0] gnt,
                      input logic vld, input logic chg, input logic to, input string name);
    bus.req_i = req;
    bus.pri_i = pri;
    expect_out(gnt, vld, chg, to, name);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    vecs[0]  = '{8'h29, P1, 3'd0, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{8'h29, P1, 3'd0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{8'h28, P1, 3'd3, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{8'h29, P1, 3'd3, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{8'h21, P1, 3'd5, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{8'h29, P1, 3'd5, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{8'h09, P1, 3'd0, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{8'h00, P1, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{8'h00, P1, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{8'h44, PP, 3'd2, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{8'h44, PP, 3'd2, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{8'h40, PP, 3'd6, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{8'h00, PP, 3'd6, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{8'h02, PN, 3'd1, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{8'h12, PN, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{8'h12, PN, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{8'h10, PN, 3'd4, 1'b1, 1'b1, 1'b0};
    vecs[17] = '{8'h00, PN, 3'd4, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{8'h80, 32'h0, 3'd7, 1'b1, 1'b1, 1'b0};
    vecs[19] = '{8'h80, 32'h0, 3'd7, 1'b1, 1'b0, 1'b0};
    vecs[20] = '{8'h00, 32'h0, 3'd7, 1'b0, 1'b0, 1'b0};
    vecs[21] = '{8'h00, 32'h0, 3'd7, 1'b0, 1'b0, 1'b0};
    vecs[22] = '{8'h29, PL, 3'd3, 1'b1, 1'b1, 1'b0};
    vecs[23] = '{8'h29, PH, 3'd3, 1'b1, 1'b0, 1'b0};
    vecs[24] = '{8'h21, PH, 3'd0, 1'b1, 1'b1, 1'b0};
    vecs[25] = '{8'h00, PH, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[26] = '{8'h01, P1, 3'd0, 1'b1, 1'b1, 1'b0};
    vecs[27] = '{8'h04, P1, 3'd2, 1'b1, 1'b1, 1'b0};
    vecs[28] = '{8'h00, P1, 3'd2, 1'b0, 1'b0, 1'b0};

    // Reset held while every master requests.
    bus.req_i = 8'hFF;
    bus.pri_i = P1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    expect_out(3'd0, 1'b0, 1'b0, 1'b0, "reset_hold");
    check_out();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expect_out(3'd0, 1'b1, 1'b1, 1'b0, "reset_release");
    check_out();
    step(8'hFF, P1, 3'd0, 1'b1, 1'b0, 1'b0, "reset_first_hold");
    step(8'h10, P1, 3'd4, 1'b1, 1'b1, 1'b0, "handover_m4");

    // Asynchronous reset mid-cycle while gnt_chg_o is high.
    #2;
    rst_n = 1'b0;
    #1;
    expect_out(3'd0, 1'b0, 1'b0, 1'b0, "reset_async");
    check_out();
    bus.req_i = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expect_out(3'd0, 1'b0, 1'b0, 1'b0, "reset_release_idle");
    check_out();

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].req, vecs[i].pri, vecs[i].gnt, vecs[i].vld, vecs[i].chg, vecs[i].to,
           $sformatf("vec%0d", i));
    end

`ifdef WB_CONMAX_ARB_TIMEOUT_EN
    step(8'h01, P1, 3'd0, 1'b1, 1'b1, 1'b0, "to_grant_m0");
    for (int i = 0; i < 3; i++) begin
      step(8'h03, P1, 3'd0, 1'b1, 1'b0, 1'b0, $sformatf("to_hold%0d", i));
    end
    step(8'h03, P1, 3'd1, 1'b1, 1'b1, 1'b1, "to_release_to_m1");
    step(8'h01, P1, 3'd0, 1'b1, 1'b1, 1'b0, "to_back_to_m0");
    for (int i = 0; i < 3; i++) begin
      step(8'h01, P1, 3'd0, 1'b1, 1'b0, 1'b0, $sformatf("to_alone_hold%0d", i));
    end
    step(8'h01, P1, 3'd0, 1'b1, 1'b0, 1'b1, "to_alone_pulse");
    step(8'h01, P1, 3'd0, 1'b1, 1'b0, 1'b0, "to_alone_after");
    step(8'h00, P1, 3'd0, 1'b0, 1'b0, 1'b0, "to_idle");
`else
    step(8'h01, P1, 3'd0, 1'b1, 1'b1, 1'b0, "nto_grant_m0");
    for (int i = 0; i < 8; i++) begin
      step(8'h03, P1, 3'd0, 1'b1, 1'b0, 1'b0, $sformatf("nto_hold%0d", i));
    end
    step(8'h02, P1, 3'd1, 1'b1, 1'b1, 1'b0, "nto_handover_m1");
    step(8'h00, P1, 3'd1, 1'b0, 1'b0, 1'b0, "nto_idle");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
